axi_noc_ni: RTL and testbench

- AXI4 slave-side network interface. It faces a GPU's AXI master port and turns each single-beat AXI write or read into a 16-bit-flit request packet on the NoC.
- It waits for the matching response packet, then completes the AXI B or R handshake.
- It is the responder/packetizer counterpart to the GPU master and its 16-bit flit port.
- One transaction is outstanding at a time.

---
 rtl/noc_pkg.sv | 15 +
 rtl/noc_flit_serializer.sv | 38 +++
 rtl/axi_noc_ni.sv | 154 +++++++++++++++
 tb/tb_axi_noc_ni.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared flit/AXI codes, header field positions and NI state type
package noc_pkg;
  localparam int FLIT_W = 16;
  localparam int NODE_W = 6;
  localparam logic [1:0] T_WRREQ = 2'b00, T_RDREQ = 2'b01, T_WRRESP = 2'b10, T_RDRESP = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  localparam int HDR_DEST_LSB = 10, HDR_TYPE_LSB = 8, HDR_SRC_LSB = 2;
  typedef enum logic [3:0] {
    IDLE, W_WAIT, TX_HDR, TX_INFO, TX_DATA, WAIT_RESP, RX_DATA, B_OUT, R_OUT, ERR_W, ERR_R
  } state_t;
  function automatic logic [FLIT_W-1:0] mk_hdr(input logic [NODE_W-1:0] dest, input logic [1:0] typ,
                                               input logic [NODE_W-1:0] src, input logic [1:0] lo);
    return {dest, typ, src, lo};
  endfunction
endpackage

// File: rtl/noc_flit_serializer.sv
// noc_flit_serializer: sends header, info and optional 4 data flits (MS first) over valid/ready
module noc_flit_serializer
  import noc_pkg::*;
(
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              en,
  input  logic [FLIT_W-1:0] hdr,
  input  logic [FLIT_W-1:0] info,
  input  logic [63:0]       word,
  input  logic              has_data,
  input  logic              net_tx_ready,
  output logic [FLIT_W-1:0] net_tx_data,
  output logic              net_tx_valid,
  output logic              hs,
  output logic              done
);
  typedef enum logic [1:0] {P_HDR, P_INFO, P_DATA} phase_t;
  phase_t ph;
  logic [1:0] beat;
  logic [5:0] bsel;
  logic last;
  assign bsel = {beat, 4'b0000};
  assign net_tx_valid = en;
  assign hs = en && net_tx_ready;
  assign last = (ph == P_INFO && !has_data) || (ph == P_DATA && beat == 2'd0);
  assign done = hs && last;
  // inputs are held by the caller for the whole packet, so the flit stays stable under backpressure
  assign net_tx_data = !en ? '0 : ph == P_HDR ? hdr : ph == P_INFO ? info : word[bsel +: FLIT_W];
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      ph <= P_HDR;
      beat <= 2'd3;
    end else if (hs) begin
      ph <= last ? P_HDR : ph == P_HDR ? P_INFO : P_DATA;
      beat <= ph == P_DATA ? beat - 2'd1 : 2'd3;
    end
endmodule

// File: rtl/axi_noc_ni.sv
// axi_noc_ni: single-outstanding AXI4 slave that packetizes writes/reads into 16-bit NoC flits
module axi_noc_ni
  import noc_pkg::*;
#(
  parameter int NODE_ID  = 27,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int ID_W     = 4,
  parameter int DEST_LSB = 13
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   S_AWID,
  input  logic [ADDR_W-1:0] S_AWADDR,
  input  logic [7:0]        S_AWLEN,
  input  logic [2:0]        S_AWSIZE,
  input  logic [1:0]        S_AWBURST,
  input  logic              S_AWVALID,
  output logic              S_AWREADY,
  input  logic [DATA_W-1:0] S_WDATA,
  input  logic [7:0]        S_WSTRB,
  input  logic              S_WLAST,
  input  logic              S_WVALID,
  output logic              S_WREADY,
  output logic [ID_W-1:0]   S_BID,
  output logic [1:0]        S_BRESP,
  output logic              S_BVALID,
  input  logic              S_BREADY,
  input  logic [ID_W-1:0]   S_ARID,
  input  logic [ADDR_W-1:0] S_ARADDR,
  input  logic [7:0]        S_ARLEN,
  input  logic [2:0]        S_ARSIZE,
  input  logic [1:0]        S_ARBURST,
  input  logic              S_ARVALID,
  output logic              S_ARREADY,
  output logic [ID_W-1:0]   S_RID,
  output logic [DATA_W-1:0] S_RDATA,
  output logic [1:0]        S_RRESP,
  output logic              S_RLAST,
  output logic              S_RVALID,
  input  logic              S_RREADY,
  output logic [FLIT_W-1:0] net_tx_data,
  output logic              net_tx_valid,
  input  logic              net_tx_ready,
  input  logic [FLIT_W-1:0] net_rx_data,
  input  logic              net_rx_valid,
  output logic              net_rx_ready,
  output logic [7:0]        err_count
);
  localparam logic [NODE_W-1:0] SELF = NODE_W'(NODE_ID);
  state_t state, nxt;
  logic [ID_W-1:0] id_q;
  logic [NODE_W-1:0] dest_q;
  logic [9:0] off_q;
  logic wr_q, aw_rdy, ar_rdy;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [1:0] resp_q;
  logic [7:0] cnt_q;
  logic aw_hs, ar_hs, w_hs, rx_hs, aw_bad, ar_bad, rx_ok, tx_hs, tx_done, tx_en;
  logic unused_ok;
  assign unused_ok = ^{S_AWBURST, S_ARBURST, S_WSTRB, S_AWADDR, S_ARADDR};
  assign S_AWREADY = aw_rdy;
  // a simultaneous write takes priority, so AR must not handshake while AWVALID is up
  assign S_ARREADY = ar_rdy && !S_AWVALID;
  assign aw_hs = S_AWVALID && S_AWREADY;
  assign ar_hs = S_ARVALID && S_ARREADY;
  assign w_hs = S_WVALID && S_WREADY;
  assign rx_hs = net_rx_valid && net_rx_ready;
  assign aw_bad = S_AWLEN != 8'd0 || S_AWSIZE != 3'd3;
  assign ar_bad = S_ARLEN != 8'd0 || S_ARSIZE != 3'd3;
  assign rx_ok = net_rx_data[HDR_DEST_LSB +: NODE_W] == SELF && net_rx_data[HDR_SRC_LSB +: NODE_W] == dest_q
              && net_rx_data[HDR_TYPE_LSB +: 2] == (wr_q ? T_WRRESP : T_RDRESP);
  assign S_WREADY = state == W_WAIT || state == ERR_W;
  assign net_rx_ready = state == WAIT_RESP || state == RX_DATA;
  assign S_BVALID = state == B_OUT;
  assign S_RVALID = state == R_OUT || state == ERR_R;
  assign S_RLAST = state == R_OUT || (state == ERR_R && cnt_q == 8'd0);
  assign S_BID = id_q;
  assign S_RID = id_q;
  assign S_BRESP = resp_q;
  assign S_RRESP = resp_q;
  assign S_RDATA = rdata_q;
  assign tx_en = state == TX_HDR || state == TX_INFO || state == TX_DATA;
  noc_flit_serializer u_ser (
    .ACLK(ACLK), .ARESETn(ARESETn), .en(tx_en),
    .hdr(mk_hdr(dest_q, wr_q ? T_WRREQ : T_RDREQ, SELF, 2'b00)),
    .info({id_q, 2'b00, off_q}), .word(wdata_q), .has_data(wr_q),
    .net_tx_ready(net_tx_ready), .net_tx_data(net_tx_data), .net_tx_valid(net_tx_valid),
    .hs(tx_hs), .done(tx_done)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = aw_hs ? (aw_bad ? ERR_W : W_WAIT) : ar_hs ? (ar_bad ? ERR_R : TX_HDR) : IDLE;
      W_WAIT:    nxt = w_hs ? TX_HDR : W_WAIT;
      TX_HDR:    nxt = tx_hs ? TX_INFO : TX_HDR;
      TX_INFO:   nxt = tx_done ? WAIT_RESP : tx_hs ? TX_DATA : TX_INFO;
      TX_DATA:   nxt = tx_done ? WAIT_RESP : TX_DATA;
      WAIT_RESP: nxt = rx_hs && rx_ok ? (wr_q ? B_OUT : RX_DATA) : WAIT_RESP;
      RX_DATA:   nxt = rx_hs && cnt_q == 8'd0 ? R_OUT : RX_DATA;
      B_OUT:     nxt = S_BREADY ? IDLE : B_OUT;
      R_OUT:     nxt = S_RREADY ? IDLE : R_OUT;
      ERR_W:     nxt = w_hs && S_WLAST ? B_OUT : ERR_W;
      ERR_R:     nxt = S_RREADY && cnt_q == 8'd0 ? IDLE : ERR_R;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      state <= IDLE;
      aw_rdy <= 1'b0;
      ar_rdy <= 1'b0;
      id_q <= '0;
      dest_q <= '0;
      off_q <= '0;
      wr_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q <= '0;
      cnt_q <= '0;
      err_count <= '0;
    end else begin
      state <= nxt;
      aw_rdy <= nxt == IDLE;
      ar_rdy <= nxt == IDLE;
      if (aw_hs) begin
        id_q <= S_AWID;
        dest_q <= S_AWADDR[DEST_LSB +: NODE_W];
        off_q <= S_AWADDR[12:3];
        wr_q <= 1'b1;
        resp_q <= aw_bad ? RESP_SLVERR : RESP_OKAY;
      end else if (ar_hs) begin
        id_q <= S_ARID;
        dest_q <= S_ARADDR[DEST_LSB +: NODE_W];
        off_q <= S_ARADDR[12:3];
        wr_q <= 1'b0;
        resp_q <= ar_bad ? RESP_SLVERR : RESP_OKAY;
        cnt_q <= S_ARLEN;
        rdata_q <= '0;
      end
      if (w_hs && state == W_WAIT) wdata_q <= S_WDATA;
      if (rx_hs && state == WAIT_RESP) begin
        if (rx_ok) begin
          resp_q <= net_rx_data[1:0];
          cnt_q <= 8'd3;
        end else if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      if (rx_hs && state == RX_DATA) begin
        rdata_q <= {rdata_q[DATA_W-FLIT_W-1:0], net_rx_data};
        cnt_q <= cnt_q - 8'd1;
      end
      if (state == ERR_R && S_RREADY) cnt_q <= cnt_q - 8'd1;
    end
endmodule

// File: tb/tb_axi_noc_ni.sv
// tb_axi_noc_ni: directed bench for axi_noc_ni with hand-computed flits and AXI responses
module tb_axi_noc_ni;
  logic ACLK = 0, ARESETn = 0;
  logic [3:0] S_AWID = 0, S_ARID = 0, S_BID, S_RID;
  logic [31:0] S_AWADDR = 0, S_ARADDR = 0;
  logic [7:0] S_AWLEN = 0, S_ARLEN = 0, S_WSTRB = 8'hFF, err_count;
  logic [2:0] S_AWSIZE = 3, S_ARSIZE = 3;
  logic [1:0] S_AWBURST = 1, S_ARBURST = 1, S_BRESP, S_RRESP;
  logic S_AWVALID = 0, S_AWREADY, S_WLAST = 0, S_WVALID = 0, S_WREADY, S_BVALID, S_BREADY = 0;
  logic S_ARVALID = 0, S_ARREADY, S_RLAST, S_RVALID, S_RREADY = 0;
  logic [63:0] S_WDATA = 0, S_RDATA;
  logic [15:0] net_tx_data, net_rx_data = 0;
  logic net_tx_valid, net_tx_ready = 1, net_rx_valid = 0, net_rx_ready;
  int vec = 0, errs = 0, tx_seen = 0;
  logic watch = 0;

  axi_noc_ni dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .net_tx_data(net_tx_data), .net_tx_valid(net_tx_valid), .net_tx_ready(net_tx_ready),
    .net_rx_data(net_rx_data), .net_rx_valid(net_rx_valid), .net_rx_ready(net_rx_ready),
    .err_count(err_count)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) if (watch && net_tx_valid) tx_seen++;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    logic hs = 0;
    S_AWID = id; S_AWADDR = addr; S_AWLEN = len; S_AWSIZE = 3; S_AWVALID = 1;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = S_AWREADY;
      tick();
    end
    S_AWVALID = 0;
    chk("aw_handshake", hs, 1);
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    logic hs = 0;
    S_ARID = id; S_ARADDR = addr; S_ARLEN = len; S_ARSIZE = 3; S_ARVALID = 1;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = S_ARREADY;
      tick();
    end
    S_ARVALID = 0;
    chk("ar_handshake", hs, 1);
  endtask

  task automatic do_w(input logic [63:0] d, input logic last);
    logic hs = 0;
    S_WDATA = d; S_WLAST = last; S_WVALID = 1;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = S_WREADY;
      tick();
    end
    S_WVALID = 0;
    chk("w_handshake", hs, 1);
  endtask

  task automatic tx_expect(input logic [15:0] exp);
    logic hs = 0;
    logic [15:0] got = 0;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = net_tx_valid && net_tx_ready;
      got = net_tx_data;
      tick();
    end
    chk("tx_flit_seen", hs, 1);
    chk("tx_flit", got, exp);
  endtask

  task automatic rx_send(input logic [15:0] f);
    logic hs = 0;
    net_rx_data = f; net_rx_valid = 1;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = net_rx_ready;
      tick();
    end
    net_rx_valid = 0;
    chk("rx_accept", hs, 1);
  endtask

  task automatic b_expect(input logic [3:0] id, input logic [1:0] resp);
    for (int i = 0; i < 50 && !S_BVALID; i++) tick();
    chk("bvalid", S_BVALID, 1);
    chk("bid", S_BID, id);
    chk("bresp", S_BRESP, resp);
    S_BREADY = 1;
    tick();
    S_BREADY = 0;
    chk("bvalid_drop", S_BVALID, 0);
  endtask

  task automatic r_expect(input logic [3:0] id, input logic [63:0] d, input logic [1:0] resp, input logic last);
    for (int i = 0; i < 50 && !S_RVALID; i++) tick();
    chk("rvalid", S_RVALID, 1);
    chk("rid", S_RID, id);
    chk("rdata", S_RDATA, d);
    chk("rresp", S_RRESP, resp);
    chk("rlast", S_RLAST, last);
    S_RREADY = 1;
    tick();
    S_RREADY = 0;
  endtask

  initial begin
    #2;
    chk("rst_awready", S_AWREADY, 0);
    chk("rst_arready", S_ARREADY, 0);
    chk("rst_wready", S_WREADY, 0);
    chk("rst_bvalid", S_BVALID, 0);
    chk("rst_rvalid", S_RVALID, 0);
    chk("rst_txvalid", net_tx_valid, 0);
    chk("rst_txdata", net_tx_data, 0);
    chk("rst_rxready", net_rx_ready, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_rdata", S_RDATA, 0);
    tick();
    ARESETn = 1;
    tick();
    chk("idle_awready", S_AWREADY, 1);
    chk("idle_arready", S_ARREADY, 1);

    // plain write
    do_aw(3, 32'h0003_9000, 0);
    chk("awready_drop", S_AWREADY, 0);
    do_w(64'hFACE_CAFE_DEAD_BEEF, 1);
    tx_expect(16'h706C); tx_expect(16'h3200);
    tx_expect(16'hFACE); tx_expect(16'hCAFE); tx_expect(16'hDEAD); tx_expect(16'hBEEF);
    chk("tx_valid_drop", net_tx_valid, 0);
    chk("wait_rxready", net_rx_ready, 1);
    rx_send(16'h6E70);
    b_expect(3, 2'b00);

    // read
    do_ar(5, 32'h0003_9000, 0);
    tx_expect(16'h716C); tx_expect(16'h5200);
    chk("rd_tx_done", net_tx_valid, 0);
    rx_send(16'h6F70); rx_send(16'h1122); rx_send(16'h3344); rx_send(16'h5566); rx_send(16'h7788);
    r_expect(5, 64'h1122334455667788, 2'b00, 1);
    chk("rvalid_drop", S_RVALID, 0);

    // backpressure on the 0xCAFE flit, then a misrouted response
    do_aw(3, 32'h0003_9000, 0);
    do_w(64'hFACE_CAFE_DEAD_BEEF, 1);
    tx_expect(16'h706C); tx_expect(16'h3200); tx_expect(16'hFACE);
    net_tx_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", net_tx_valid, 1);
      chk("bp_data", net_tx_data, 16'hCAFE);
      tick();
    end
    net_tx_ready = 1;
    tx_expect(16'hCAFE); tx_expect(16'hDEAD); tx_expect(16'hBEEF);
    chk("bp_tx_done", net_tx_valid, 0);
    rx_send(16'h6E74);
    chk("bad_errcnt", err_count, 1);
    chk("bad_still_wait", net_rx_ready, 1);
    chk("bad_no_b", S_BVALID, 0);
    rx_send(16'h6E72);
    b_expect(3, 2'b10);

    // simultaneous AW/AR: the write must go first
    S_AWID = 3; S_AWADDR = 32'h0003_9000; S_AWLEN = 0; S_AWVALID = 1;
    S_ARID = 5; S_ARADDR = 32'h0003_9000; S_ARLEN = 0; S_ARVALID = 1;
    #1;
    chk("both_awready", S_AWREADY, 1);
    chk("both_arready", S_ARREADY, 0);
    tick();
    S_AWVALID = 0;
    #1;
    chk("both_arready_wr", S_ARREADY, 0);
    do_w(64'h0123_4567_89AB_CDEF, 1);
    tx_expect(16'h706C); tx_expect(16'h3200);
    tx_expect(16'h0123); tx_expect(16'h4567); tx_expect(16'h89AB); tx_expect(16'hCDEF);
    rx_send(16'h6E70);
    chk("both_arready_b", S_ARREADY, 0);
    b_expect(3, 2'b00);
    do_ar(5, 32'h0003_9000, 0);
    tx_expect(16'h716C); tx_expect(16'h5200);
    rx_send(16'h6F71); rx_send(16'hA1A2); rx_send(16'hB1B2); rx_send(16'hC1C2); rx_send(16'hD1D2);
    r_expect(5, 64'hA1A2B1B2C1C2D1D2, 2'b01, 1);

    // unsupported read burst
    watch = 1;
    do_ar(7, 32'h0003_9000, 2);
    r_expect(7, 64'h0, 2'b10, 0);
    r_expect(7, 64'h0, 2'b10, 0);
    r_expect(7, 64'h0, 2'b10, 1);
    chk("err_r_done", S_RVALID, 0);

    // unsupported write burst
    do_aw(2, 32'h0003_9000, 1);
    do_w(64'h1, 0);
    chk("err_w_no_b", S_BVALID, 0);
    do_w(64'h2, 1);
    b_expect(2, 2'b10);
    watch = 0;
    chk("err_no_tx", tx_seen, 0);
    chk("final_errcnt", err_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
